// File: rtl/fftram_frame_ctrl.sv
// Purpose: fill a 2**ADDR_W-sample frame into a single-port RAM, then stream it out to the FFT as one burst.
// Latency: first out_valid 3 cycles after the last sample is accepted if fft_ready is already high.
// Backpressure: in_ready is high only while filling; offered samples outside fill are dropped and set sticky ovf.
// Build option: FFTRAM_BITREV_EN selects bit-reversed readout; when it is undefined the readout is in natural order.
module fftram_frame_ctrl #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 23
) (
  input  logic              clka,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  input  logic              fft_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              ovf,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout
);

  typedef enum logic [1:0] {
    S_FILL  = 2'd0,
    S_FULL  = 2'd1,
    S_READ  = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0] CNT_MAX = '1;

  state_t            state;
  logic [ADDR_W-1:0] wr_cnt;
  logic [ADDR_W-1:0] rd_cnt;

  // Read-order address map: bit reversal gives decimation-in-time order.
  function automatic logic [ADDR_W-1:0] addr_map(input logic [ADDR_W-1:0] a);
    logic [ADDR_W-1:0] r;
`ifdef FFTRAM_BITREV_EN
    for (int i = 0; i < ADDR_W; i++) begin
      r[i] = a[ADDR_W-1-i];
    end
`else
    r = a;
`endif
    return r;
  endfunction

  // Frame sequencer: state, counters, registered stream flags and sticky overflow.
  always_ff @(posedge clka or posedge rst) begin
    if (rst) begin
      state     <= S_FILL;
      wr_cnt    <= '0;
      rd_cnt    <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      // RAM read data arrives one cycle after the address, so the flags trail the read state by one cycle.
      out_valid <= (state == S_READ);
      out_last  <= (state == S_READ) && (rd_cnt == CNT_MAX);
      if (in_valid && (state != S_FILL)) begin
        ovf <= 1'b1;
      end
      case (state)
        S_FILL: begin
          if (in_valid) begin
            wr_cnt <= wr_cnt + 1'b1;
            if (wr_cnt == CNT_MAX) begin
              state <= S_FULL;
            end
          end
        end
        S_FULL: begin
          if (fft_ready) begin
            rd_cnt <= '0;
            state  <= S_READ;
          end
        end
        S_READ: begin
          // The burst never stalls; fft_ready was a promise for the whole frame.
          rd_cnt <= rd_cnt + 1'b1;
          if (rd_cnt == CNT_MAX) begin
            state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          wr_cnt <= '0;
          state  <= S_FILL;
        end
        default: begin
          state <= S_FILL;
        end
      endcase
    end
  end

  // RAM port steering: the single port belongs to the writer in fill and to the reader in read.
  always_comb begin
    in_ready = (state == S_FILL);
    ram_we   = 1'b0;
    ram_addr = '0;
    case (state)
      S_FILL: begin
        ram_we   = in_valid;
        ram_addr = wr_cnt;
      end
      S_READ: begin
        ram_addr = addr_map(rd_cnt);
      end
      default: begin
        ram_we   = 1'b0;
        ram_addr = '0;
      end
    endcase
  end

  assign ram_din  = in_data;
  assign out_data = ram_dout;

endmodule

// File: tb/tb_fftram_frame_ctrl.sv
// Bench for fftram_frame_ctrl: frame scenarios from a table plus reset-abort sequences.
// Readout is checked against a scoreboard queue loaded from the bench's own copy of each frame.
// The RAM behind the block is a 256x23 write-first single-port model.
module tb_fftram_frame_ctrl;

  logic        clka = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [22:0] in_data = '0;
  logic        in_ready;
  logic        fft_ready = 1'b0;
  logic        out_valid;
  logic [22:0] out_data;
  logic        out_last;
  logic        ovf;
  logic        ram_we;
  logic [7:0]  ram_addr;
  logic [22:0] ram_din;
  logic [22:0] ram_dout;

  fftram_frame_ctrl dut (
    .clka      (clka),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .fft_ready (fft_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
    .ovf       (ovf),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_din   (ram_din),
    .ram_dout  (ram_dout)
  );

  always #5 clka = ~clka;

  // write-first single-port RAM model
  logic [22:0] mem [256];
  always @(posedge clka) begin
    if (ram_we) begin
      mem[ram_addr] <= ram_din;
      ram_dout      <= ram_din;
    end else begin
      ram_dout <= mem[ram_addr];
    end
  end

  int cyc = 0;
  always @(posedge clka) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int tb_map(input int k);
    int r;
`ifdef FFTRAM_BITREV_EN
    r = 0;
    for (int j = 0; j < 8; j++) begin
      if (k[j]) r = r | (1 << (7 - j));
    end
`else
    r = k;
`endif
    return r;
  endfunction

  // scoreboard and monitor state
  logic [22:0] exp_q [$];
  logic [22:0] gold [256];
  logic [22:0] cap [256];
  int nvalid = 0;
  int first_cyc = -1;
  int last_wr = 0;
  int ref_cyc = 0;
  bit last_seen = 0;

  always @(negedge clka) begin
    if (out_valid) begin
      if (nvalid < 256) cap[nvalid] = out_data;
      if (first_cyc < 0) first_cyc = cyc;
      nvalid++;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_valid: got out_valid=1, want 0 (cycle %0d)", cyc);
      end else begin
        chk("rd_data", out_data, exp_q.pop_front());
      end
      chk("out_last_pos", out_last, (nvalid == 256));
      if (out_last) begin
        last_seen = 1;
        chk("ready_in_drain", in_ready, 0);
      end
    end else if (out_last) begin
      total++;
      bad++;
      $display("FAIL last_without_valid: got out_last=1, want 0 (cycle %0d)", cyc);
    end
  end

  task automatic clear_mon();
    exp_q.delete();
    nvalid    = 0;
    first_cyc = -1;
    last_seen = 0;
  endtask

  // assert reset mid-cycle, check reset outputs, release after two edges
  task automatic do_reset();
    in_valid  = 0;
    fft_ready = 0;
    rst       = 1;
    clear_mon();
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_ram_we", ram_we, 0);
    chk("rst_ram_addr", ram_addr, 0);
    repeat (2) @(posedge clka);
    #1;
    rst = 0;
  endtask

  // offer n samples base+stride*i, with random idle gaps
  task automatic fill(input int n, input int gap, input int base, input int stride);
    for (int i = 0; i < n; i++) begin
      int g = 0;
      while (g < 4 && int'($urandom_range(99)) < gap) begin
        in_valid = 0;
        g++;
        @(posedge clka);
        #1;
      end
      in_valid = 1;
      in_data  = 23'(base + stride * i);
      gold[i]  = 23'(base + stride * i);
      last_wr  = cyc;
      @(posedge clka);
      #1;
    end
    in_valid = 0;
  endtask

  task automatic push_exp();
    for (int k = 0; k < 256; k++) exp_q.push_back(gold[tb_map(k)]);
  endtask

  task automatic wait_burst();
    for (int n = 0; n < 700 && !last_seen; n++) @(posedge clka);
    #1;
    if (!last_seen) begin
      total++;
      bad++;
      $display("FAIL burst_timeout: got no out_last, want one within 700 cycles");
    end
  endtask

  task automatic wait_nvalid(input int target);
    for (int n = 0; n < 400 && nvalid < target; n++) begin
      @(posedge clka);
      #1;
    end
    chk("reach_nvalid", (nvalid >= target), 1);
  endtask

  typedef struct {
    int gap;        // percent of idle cycles inserted during fill
    int hold;       // cycles fft_ready stays low after fill (0: high during fill)
    int junk_full;  // offer samples while full
    int junk_read;  // offer samples mid-burst
    int drop_mid;   // drop fft_ready mid-burst
    int base;
    int stride;
    int exp_lat;    // first out_valid relative to last write (hold=0) or fft_ready rise
    int exp_ovf;
  } vec_t;

  task automatic run_frame(input vec_t v, input int idx);
    bit ok;
    clear_mon();
    fft_ready = (v.hold == 0);
    fill(256, v.gap, v.base, v.stride);
    push_exp();
    if (v.hold > 0) begin
      ok = 1;
      for (int h = 0; h < v.hold; h++) begin
        in_valid = (v.junk_full != 0) && (h < 5);
        in_data  = 23'h5a5a5a;
        @(negedge clka);
        if (in_ready !== 1'b0 || out_valid !== 1'b0) ok = 0;
        @(posedge clka);
        #1;
      end
      in_valid = 0;
      chk("hold_idle", ok, 1);
      fft_ready = 1;
      ref_cyc   = cyc;
    end else begin
      ref_cyc = last_wr;
    end
    if (v.drop_mid != 0 || v.junk_read != 0) begin
      wait_nvalid(100);
      if (v.drop_mid != 0) fft_ready = 0;
      if (v.junk_read != 0) begin
        in_valid = 1;
        in_data  = 23'h3c3c3c;
        repeat (3) begin
          @(posedge clka);
          #1;
        end
        in_valid = 0;
      end
    end
    wait_burst();
    chk("first_latency", first_cyc - ref_cyc, v.exp_lat);
    chk("burst_len", nvalid, 256);
    chk("ovf", ovf, v.exp_ovf);
    chk("queue_empty", exp_q.size(), 0);
    chk("ready_after_drain", in_ready, 1);
    if (idx == 0) begin
`ifdef FFTRAM_BITREV_EN
      chk("seq0", cap[0], 0);
      chk("seq1", cap[1], 256);
      chk("seq2", cap[2], 128);
      chk("seq3", cap[3], 384);
`else
      chk("seq0", cap[0], 0);
      chk("seq1", cap[1], 2);
      chk("seq2", cap[2], 4);
      chk("seq3", cap[3], 6);
`endif
      chk("seq_end", cap[255], 510);
    end
  endtask

  vec_t vecs [6];
  vec_t plain;

  initial begin
    //           gap hold jf jr dm base    stride lat ovf
    vecs[0] = '{0,  0,  0, 0, 0, 0,      2,  3, 0};
    vecs[1] = '{0,  50, 0, 0, 1, 1000,   7,  2, 0};
    vecs[2] = '{0,  10, 1, 0, 0, 5,      3,  2, 1};
    vecs[3] = '{0,  0,  0, 1, 0, 77,     11, 3, 1};
    vecs[4] = '{50, 0,  0, 0, 0, 300000, 13, 3, 1};
    vecs[5] = '{50, 5,  0, 0, 1, 4242,   5,  2, 1};
    plain   = '{0,  0,  0, 0, 0, 20000,  9,  3, 0};

    do_reset();
    for (int i = 0; i < 6; i++) run_frame(vecs[i], i);

    // reset part-way through a fill: nothing must come out, next frame starts clean
    do_reset();
    fft_ready = 1;
    fill(100, 0, 9, 1);
    do_reset();
    run_frame(plain, 1);

    // reset at read 40 of a burst: no out_last, outputs back to reset values
    clear_mon();
    fft_ready = 1;
    fill(256, 0, 60000, 3);
    push_exp();
    wait_nvalid(40);
    do_reset();
    chk("no_last_after_abort", last_seen, 0);
    plain.base = 123;
    run_frame(plain, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
